matrix_run_ctrl: RTL and testbench
==================================

# matrix_run_ctrl

Run sequencer and spin readout for the coupled-oscillator matrix. On a host start command it holds the matrix oscillators in reset, releases them for a programmed anneal time, then measures each oscillator's phase against oscillator 0 over a fixed window. It resolves a binary spin vector, then parks the matrix. It sits between the host register block and the matrix's `ising_rstn` / `bot_row` pins, in the same `clk` domain as weight programming.

## Interface
Parameters:
- `N`, 8: oscillator count; equals matrix `N`, power of two, ≥2.
- `RST_CYCLES`, 16: cycles `ising_rstn` is held low before each run, ≥1.
- `SAMPLE_LOG2`, 8: phase window is 2^SAMPLE_LOG2 cycles, 1..16.

Ports:
- `clk`  in  1  system clock.
- `axi_rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle run request.
- `abort`  in  1  single-cycle cancel.
- `run_cycles`  in  32  anneal length in cycles; latched on accepted `start`.
- `bot_row`  in  N  raw oscillator outputs; asynchronous to `clk`.
- `ising_rstn`  out  1  matrix oscillator reset, active-low, registered.
- `busy`  out  1  high in RESET, RUN or SAMPLE.
- `done`  out  1  high in DONE.
- `spins`  out  N  resolved spins; bit 0 is the reference and is always 1.
- `wr_block`  out  1  equals `busy`; the host gates weight writes with it.

## Operation
- States: IDLE, RESET, RUN, SAMPLE, DONE. Encoding lives in `defines.vh`.
- `start` is accepted only in IDLE or DONE. In the other states it is ignored and does not change `run_cycles`.
- **IDLE or DONE + start:** go to RESET, latch `run_cycles`, clear the timer.
- **RESET:** `ising_rstn` = 0. Stay RST_CYCLES cycles, then go to RUN.
- **RUN:** `ising_rstn` = 1. Stay `run_cycles` cycles, then go to SAMPLE. If the latched value is 0, RUN lasts exactly 1 cycle and then moves to SAMPLE.
- **SAMPLE:** `ising_rstn` = 1. Stays 2^SAMPLE_LOG2 cycles.
  - `bot_row` passes through 2-FF synchronizers giving `s[N-1:0]`.
  - Each SAMPLE cycle, `agree[i]` increments when `s[i] == s[0]`.
  - Counters are SAMPLE_LOG2+1 bits wide, cleared on SAMPLE entry, and cannot overflow.
- **SAMPLE exit:** `spins[i]` = (`agree[i]` ≥ 2^(SAMPLE_LOG2-1)), then go to DONE.
- **DONE:** `ising_rstn` = 0. Hold `spins` and stay until `start` or `abort`.
- **abort:** in any state, go to IDLE next cycle with `ising_rstn` = 0. `spins` keeps its last value. `abort` wins over a simultaneous `start`.
- `spins` updates only on SAMPLE exit.

## Timing
- **Reset values:** state IDLE, `ising_rstn` 0, `busy` 0, `done` 0, `wr_block` 0, `spins` 0, timer and counters 0, synchronizers 0.
- **Run sequence:** `start` sampled high at edge t gives:
  - state RESET and `busy` = 1 after edge t.
  - `ising_rstn` rises after edge t+RST_CYCLES.
  - SAMPLE entered after edge t+RST_CYCLES+max(R,1), where R is the latched `run_cycles`.
  - DONE, `done` = 1 and valid `spins` after edge t+RST_CYCLES+max(R,1)+2^SAMPLE_LOG2.
  - `ising_rstn` = 0 in that same cycle.
- **Restart from DONE:** `start` in DONE drops `done` the next cycle. There is no IDLE gap.
- **Synchronizer latency:** the first SAMPLE-cycle sample reflects `bot_row` 2 cycles earlier, while the oscillators are still running. This is accepted.
- **Timer:** 32-bit down-counter, compared registered. `run_cycles` = 0xFFFF_FFFF must not wrap early.
- **Reset mid-run:** asserting `axi_rstn` asynchronously forces all reset values, including `ising_rstn` 0.

## Structure
- `defines.vh`: state encodings, `MRC_IDLE` … `MRC_DONE`.
- One sub-module, `bit_sync`: a 2-FF synchronizer with async active-low reset, instantiated N times.
- Agreement counters and spin compare are a generate loop over N in the top module.
- Expected size: about 200 lines.

## Test plan
All scenarios use N=8, RST_CYCLES=4, SAMPLE_LOG2=4 unless stated.

- **Basic run:** reset, then `start` with `run_cycles`=10. `ising_rstn` is low for 4 cycles and high for 10+16 cycles. `done` rises exactly 30 cycles after `start`, then `ising_rstn` = 0.
- **Phase resolution:** model drives all bits with the same 8-cycle-period square wave, bits 3 and 5 inverted → `spins` = 8'b1101_0111. With 90° skew on bit 2 → `agree[2]` = 8, `spins[2]` = 1 (the threshold is inclusive).
- **run_cycles = 0:** RUN lasts exactly 1 cycle → `done` 21 cycles after `start`.
- **Start while busy:** second `start` with `run_cycles`=99 in the middle of RUN → ignored, timing is unchanged from the first start.
- **Abort:** `abort` in SAMPLE → IDLE next cycle, `busy` = 0, `done` = 0, `spins` = previous value. Same-cycle `start` + `abort` in DONE → IDLE.
- **Async reset mid-RUN:** pulse `axi_rstn` low → outputs reach reset values without a clock edge. The next `start` runs normally.

Source files
------------

// File: rtl/matrix_run_ctrl_pkg.sv
// Shared types and helpers for the oscillator-matrix run sequencer.
package matrix_run_ctrl_pkg;

  // Sequencer states; the encoding is fixed so waveforms stay readable.
  typedef enum logic [2:0] {
    MRC_IDLE   = 3'd0,
    MRC_RESET  = 3'd1,
    MRC_RUN    = 3'd2,
    MRC_SAMPLE = 3'd3,
    MRC_DONE   = 3'd4
  } mrc_state_e;

  localparam int unsigned TIMER_W = 32;

  // Timer reload for the anneal phase: a zero-length request still spends
  // one cycle in RUN, so 0 and 1 both load a terminal count of 0.
  function automatic logic [TIMER_W-1:0] run_load(input logic [TIMER_W-1:0] r);
    logic [TIMER_W-1:0] v;
    if (r == 32'd0) begin
      v = 32'd0;
    end else begin
      v = r - 32'd1;
    end
    return v;
  endfunction

endpackage

// File: rtl/matrix_run_ctrl_bit_sync.sv
// Two-flop synchronizer for one asynchronous oscillator output.
module bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  // Two back-to-back flops to let metastability settle before use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/matrix_run_ctrl.sv
// Run sequencer and spin readout for the coupled-oscillator matrix:
// reset -> anneal -> phase sampling -> spin vector, with abort.
module matrix_run_ctrl
  import matrix_run_ctrl_pkg::*;
#(
  parameter int N           = 8,
  parameter int RST_CYCLES  = 16,
  parameter int SAMPLE_LOG2 = 8
) (
  input  logic          clk,
  input  logic          axi_rstn,
  input  logic          start,
  input  logic          abort,
  input  logic [31:0]   run_cycles,
  input  logic [N-1:0]  bot_row,
  output logic          ising_rstn,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  spins,
  output logic          wr_block
);

  localparam int CNT_W = SAMPLE_LOG2 + 1;
  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SAMPLE_LAST = TIMER_W'((2 ** SAMPLE_LOG2) - 1);
  // Inclusive majority threshold: exactly half agreement resolves to 1.
  localparam logic [CNT_W-1:0]   THRESH      = CNT_W'(2 ** (SAMPLE_LOG2 - 1));

  mrc_state_e           state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [31:0]          run_q, run_d;
  logic [N-1:0]         spins_q, spins_d;
  logic                 rstn_q, rstn_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 sample_clr_s;
  logic                 sample_last_s;
  logic                 timer_zero_s;
  logic [N-1:0]         s_sync;
  logic [N-1:0]         spin_new_s;

  assign timer_zero_s = (timer_q == 32'd0);

  // Next-state, timer reload and phase strobes; abort overrides everything.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    run_d         = run_q;
    sample_clr_s  = 1'b0;
    sample_last_s = 1'b0;
    if (abort) begin
      state_d = MRC_IDLE;
      timer_d = 32'd0;
    end else begin
      case (state_q)
        MRC_IDLE, MRC_DONE: begin
          if (start) begin
            state_d = MRC_RESET;
            run_d   = run_cycles;
            timer_d = RST_LAST;
          end else begin
            state_d = state_q;
          end
        end
        MRC_RESET: begin
          if (timer_zero_s) begin
            state_d = MRC_RUN;
            timer_d = run_load(run_q);
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
        MRC_RUN: begin
          if (timer_zero_s) begin
            state_d      = MRC_SAMPLE;
            timer_d      = SAMPLE_LAST;
            sample_clr_s = 1'b1;
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
        MRC_SAMPLE: begin
          if (timer_zero_s) begin
            state_d       = MRC_DONE;
            timer_d       = 32'd0;
            sample_last_s = 1'b1;
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end
        default: begin
          state_d = MRC_IDLE;
          timer_d = 32'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    rstn_d  = (state_d == MRC_RUN) || (state_d == MRC_SAMPLE);
    busy_d  = (state_d == MRC_RESET) || (state_d == MRC_RUN) ||
              (state_d == MRC_SAMPLE);
    done_d  = (state_d == MRC_DONE);
    if (sample_last_s) begin
      spins_d = spin_new_s;
    end else begin
      spins_d = spins_q;
    end
  end

  // Sequencer state, timer and registered outputs.
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q <= MRC_IDLE;
      timer_q <= 32'd0;
      run_q   <= 32'd0;
      spins_q <= '0;
      rstn_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      run_q   <= run_d;
      spins_q <= spins_d;
      rstn_q  <= rstn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Per-oscillator synchronizer, agreement counter and majority decision.
  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    logic [CNT_W-1:0] agree_q;
    logic [CNT_W-1:0] agree_inc_s;
    logic             match_s;

    bit_sync u_sync (
      .clk   (clk),
      .rst_n (axi_rstn),
      .d_i   (bot_row[gi]),
      .q_o   (s_sync[gi])
    );

    assign match_s     = (s_sync[gi] == s_sync[0]);
    // Includes the current cycle so the final SAMPLE cycle counts at exit.
    assign agree_inc_s = agree_q + {{(CNT_W-1){1'b0}}, match_s};
    assign spin_new_s[gi] = (agree_inc_s >= THRESH);

    // Count cycles in phase with oscillator 0; zeroed on SAMPLE entry.
    always_ff @(posedge clk or negedge axi_rstn) begin
      if (!axi_rstn) begin
        agree_q <= '0;
      end else if (sample_clr_s) begin
        agree_q <= '0;
      end else if (state_q == MRC_SAMPLE) begin
        agree_q <= agree_inc_s;
      end
    end
  end

  assign ising_rstn = rstn_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign wr_block   = busy_q;
  assign spins      = spins_q;

endmodule

// File: tb/tb_matrix_run_ctrl.sv
// Scoreboard bench for matrix_run_ctrl (N=8, RST_CYCLES=4, SAMPLE_LOG2=4).
module tb_matrix_run_ctrl;

  logic        clk = 1'b0;
  logic        axi_rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] run_cycles = 32'd0;
  logic [7:0]  bot_row;
  logic        ising_rstn;
  logic        busy;
  logic        done;
  logic [7:0]  spins;
  logic        wr_block;

  matrix_run_ctrl #(.N(8), .RST_CYCLES(4), .SAMPLE_LOG2(4)) dut (
    .clk        (clk),
    .axi_rstn   (axi_rstn),
    .start      (start),
    .abort      (abort),
    .run_cycles (run_cycles),
    .bot_row    (bot_row),
    .ising_rstn (ising_rstn),
    .busy       (busy),
    .done       (done),
    .spins      (spins),
    .wr_block   (wr_block)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator model: 8-cycle square wave, per-bit inversion, optional
  // 2-cycle (90 degree) skew on bit 2.
  logic [2:0] ph = 3'd0;
  logic [2:0] phs;
  logic [7:0] inv = 8'h00;
  logic       skew2 = 1'b0;
  always @(posedge clk) ph <= ph + 3'd1;
  assign phs = ph - 3'd2;
  always_comb begin
    bot_row = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bot_row[i] = (((i == 2) && skew2) ? phs[2] : ph[2]) ^ inv[i];
    end
  end

  typedef struct {
    int         cyc;
    logic [7:0] sp;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every rising edge of done pops one expectation.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("spins", {24'd0, spins}, {24'd0, e.sp});
        chk("rstn_low_at_done", {31'd0, ising_rstn}, 32'd0);
        chk("busy_low_at_done", {31'd0, busy}, 32'd0);
      end
    end
    done_prev <= done;
  end

  int t0;

  task automatic do_start(input logic [31:0] r, input int lat, input logic [7:0] sp, input bit push);
    @(negedge clk);
    start = 1'b1;
    run_cycles = r;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
    if (push) sb_q.push_back('{t0 + lat, sp});
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_wr_block", {31'd0, wr_block}, 32'd1);
    chk("start_done_low", {31'd0, done}, 32'd0);
    chk("start_rstn_low", {31'd0, ising_rstn}, 32'd0);
  endtask

  task automatic wait_sb(input int bound);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() != 0) begin
      chk("done_timeout", 32'd1, 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rstn"}, {31'd0, ising_rstn}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_wr_block"}, {31'd0, wr_block}, 32'd0);
    chk({tag, "_spins"}, {24'd0, spins}, 32'd0);
  endtask

  initial begin
    // Reset state
    #22;
    chk_reset_vals("reset");
    @(negedge clk);
    axi_rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Basic run, bits 3 and 5 inverted
    inv = 8'b0010_1000;
    skew2 = 1'b0;
    do_start(32'd10, 30, 8'hD7, 1'b1);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("basic_rstn_profile", {31'd0, ising_rstn}, (k >= 4) ? 32'd1 : 32'd0);
    end
    wait_sb(40);

    // Restart from DONE with run_cycles=0, skew on bit 2, bit 6 inverted
    inv = 8'b0100_0000;
    skew2 = 1'b1;
    do_start(32'd0, 21, 8'hBF, 1'b1);
    wait_sb(40);

    // Start while busy: second request in RUN is ignored
    inv = 8'b0010_1000;
    skew2 = 1'b0;
    do_start(32'd5, 25, 8'hD7, 1'b1);
    repeat (6) @(negedge clk);
    start = 1'b1;
    run_cycles = 32'd99;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_start_still_busy", {31'd0, busy}, 32'd1);
    wait_sb(60);

    // Abort in SAMPLE: spins keep the previous result
    inv = 8'h00;
    do_start(32'd2, 0, 8'h00, 1'b0);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_rstn", {31'd0, ising_rstn}, 32'd0);
    chk("abort_spins", {24'd0, spins}, 32'h0000_00D7);
    repeat (30) @(negedge clk);
    chk("abort_stays_idle", {31'd0, busy | done}, 32'd0);

    // Run from IDLE, then start+abort together in DONE
    inv = 8'b0010_1000;
    do_start(32'd1, 21, 8'hD7, 1'b1);
    wait_sb(40);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    run_cycles = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", {31'd0, busy}, 32'd0);
    chk("start_abort_done", {31'd0, done}, 32'd0);
    repeat (10) @(negedge clk);
    chk("start_abort_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of RUN
    do_start(32'd50, 0, 8'h00, 1'b0);
    repeat (10) @(negedge clk);
    chk("pre_areset_rstn", {31'd0, ising_rstn}, 32'd1);
    #2;
    axi_rstn = 1'b0;
    #1;
    chk_reset_vals("areset");
    @(negedge clk);
    axi_rstn = 1'b1;
    inv = 8'b0100_0000;
    skew2 = 1'b1;
    do_start(32'd3, 23, 8'hBF, 1'b1);
    wait_sb(40);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
